// File: rtl/loader_pkg.sv
// Shared types for the UART program loader: FSM states and the error codes
// reported on O_ERR_CODE.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BYTES = 2'd1,
        WRITE = 2'd2,
        CSUM  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_COUNT   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_CSUM    = 2'b11;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle watchdog: counts cycles while run is high, restarts on clear,
// and flags the idle cycle that would bring the count up to TIMEOUT_CYC.
module loader_timeout #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int            CW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] idle_cnt;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            idle_cnt <= '0;
        else if (clear)
            idle_cnt <= '0;
        else if (run)
            idle_cnt <= idle_cnt + CW'(1);
    end

    // Asserting one cycle early lets the FSM leave on the edge that completes the count.
    assign expired = run && !clear && (idle_cnt == LIMIT);

endmodule

// File: rtl/uart_program_loader.sv
// Pulls a counted, checksummed program image out of the UART RX FIFO and
// writes it word by word into the MIPS program memory.
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              I_ENABLE,
    input  logic              I_RX_EMPTY,
    input  logic [7:0]        I_R_DATA,
    output logic              O_RD_UART,
    output logic              O_WR_PM,
    output logic [ADDR_W-1:0] O_ADDR_PM,
    output logic [31:0]       O_DATA_PM,
    output logic              O_BUSY,
    output logic              O_DONE,
    output logic              O_ERROR,
    output logic [1:0]        O_ERR_CODE,
    output logic              O_LOADED,
    output logic [7:0]        O_N_INSTR
);

    localparam int CW        = ADDR_W + 1;
    localparam int MAX_WORDS = 1 << ADDR_W;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  word_cnt;
    logic [1:0]     byte_idx;
    logic [7:0]     csum;
    logic [31:0]    data_word;

    logic in_load;
    logic pop;
    logic expired;
    logic count_bad;
    logic start_ok;
    logic start_bad;
    logic csum_ok;
    logic csum_bad;
    logic timed_out;

    assign in_load   = (state == BYTES) || (state == CSUM);
    assign pop       = !I_RX_EMPTY && (in_load || ((state == IDLE) && I_ENABLE));
    assign O_RD_UART = pop;
    assign count_bad = (I_R_DATA == 8'd0) || ({24'd0, I_R_DATA} > 32'(MAX_WORDS));
    assign O_ADDR_PM = word_cnt[ADDR_W-1:0];
    assign O_DATA_PM = data_word;

    loader_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .CLK     (CLK),
        .RESET   (RESET),
        .clear   (pop || !in_load),
        .run     (in_load && !pop),
        .expired (expired)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        start_bad  = 1'b0;
        csum_ok    = 1'b0;
        csum_bad   = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (pop) begin
                    if (count_bad) begin
                        start_bad = 1'b1;
                    end else begin
                        start_ok   = 1'b1;
                        state_next = BYTES;
                    end
                end
            end
            BYTES: begin
                if (pop) begin
                    if (byte_idx == 2'd3)
                        state_next = WRITE;
                end else if (expired) begin
                    timed_out  = 1'b1;
                    state_next = IDLE;
                end
            end
            WRITE: begin
                state_next = ((word_cnt + CW'(1)) == CW'(O_N_INSTR)) ? CSUM : BYTES;
            end
            CSUM: begin
                if (pop) begin
                    csum_ok    = (I_R_DATA == csum);
                    csum_bad   = (I_R_DATA != csum);
                    state_next = IDLE;
                end else if (expired) begin
                    timed_out  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            word_cnt   <= '0;
            byte_idx   <= '0;
            csum       <= '0;
            data_word  <= '0;
            O_WR_PM    <= 1'b0;
            O_BUSY     <= 1'b0;
            O_DONE     <= 1'b0;
            O_ERROR    <= 1'b0;
            O_ERR_CODE <= ERR_NONE;
            O_LOADED   <= 1'b0;
            O_N_INSTR  <= '0;
        end else begin
            O_WR_PM <= (state_next == WRITE);
            O_BUSY  <= (state_next != IDLE);
            O_DONE  <= csum_ok;
            O_ERROR <= start_bad || csum_bad || timed_out;

            // Any header, accepted or not, invalidates the previous image.
            if (start_ok || start_bad) begin
                O_LOADED   <= 1'b0;
                O_N_INSTR  <= I_R_DATA;
                O_ERR_CODE <= start_bad ? ERR_COUNT : ERR_NONE;
            end
            if (start_ok) begin
                word_cnt <= '0;
                byte_idx <= '0;
                csum     <= '0;
            end
            if ((state == BYTES) && pop) begin
                data_word <= {data_word[23:0], I_R_DATA};
                csum      <= csum ^ I_R_DATA;
                byte_idx  <= byte_idx + 2'd1;
            end
            if (state == WRITE)
                word_cnt <= word_cnt + CW'(1);
            if (csum_ok)
                O_LOADED <= 1'b1;
            if (csum_bad)
                O_ERR_CODE <= ERR_CSUM;
            if (timed_out)
                O_ERR_CODE <= ERR_TIMEOUT;
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: a byte-queue FIFO model feeds the
// DUT while a scoreboard checks every program-memory write and status pulse.
module tb_uart_program_loader;

    localparam int ADDR_W      = 5;
    localparam int TIMEOUT_CYC = 16;

    logic              CLK        = 1'b0;
    logic              RESET      = 1'b0;
    logic              I_ENABLE   = 1'b0;
    logic              I_RX_EMPTY = 1'b1;
    logic [7:0]        I_R_DATA   = 8'h00;
    logic              O_RD_UART;
    logic              O_WR_PM;
    logic [ADDR_W-1:0] O_ADDR_PM;
    logic [31:0]       O_DATA_PM;
    logic              O_BUSY;
    logic              O_DONE;
    logic              O_ERROR;
    logic [1:0]        O_ERR_CODE;
    logic              O_LOADED;
    logic [7:0]        O_N_INSTR;

    uart_program_loader #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .I_ENABLE   (I_ENABLE),
        .I_RX_EMPTY (I_RX_EMPTY),
        .I_R_DATA   (I_R_DATA),
        .O_RD_UART  (O_RD_UART),
        .O_WR_PM    (O_WR_PM),
        .O_ADDR_PM  (O_ADDR_PM),
        .O_DATA_PM  (O_DATA_PM),
        .O_BUSY     (O_BUSY),
        .O_DONE     (O_DONE),
        .O_ERROR    (O_ERROR),
        .O_ERR_CODE (O_ERR_CODE),
        .O_LOADED   (O_LOADED),
        .O_N_INSTR  (O_N_INSTR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct {
        logic       done;
        logic [1:0] code;
    } evt_t;

    typedef struct {
        logic [7:0] n;
        logic [7:0] csum_flip;
        bit         stall;
        logic       exp_done;
        logic [1:0] exp_code;
    } vec_t;

    wr_t         exp_wr[$];
    evt_t        exp_evt[$];
    logic [7:0]  fifo[$];
    logic [31:0] cur_words[$];
    vec_t        vecs[$];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   pops = 0;
    int   last_pop_cyc = 0;
    int   evt_cyc = 0;
    int   wr_seen = 0;
    logic rd_seen = 1'b0;
    logic hold_empty = 1'b0;
    bit   stall_en = 1'b0;
    int   stall_run = 0;
    wr_t  w_got;
    evt_t e_got;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic void present();
        I_RX_EMPTY = hold_empty || (fifo.size() == 0);
        I_R_DATA   = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        fifo.push_back(b);
        present();
    endtask

    // Sample the pop strobe just before the edge that acts on it.
    always @(negedge CLK) begin
        #4;
        rd_seen = O_RD_UART;
    end

    // FIFO model: consume the head byte on each popped edge, optionally stall.
    always @(posedge CLK) begin
        #1;
        cyc++;
        if (rd_seen && fifo.size() != 0) begin
            void'(fifo.pop_front());
            pops++;
            last_pop_cyc = cyc;
        end
        rd_seen = 1'b0;
        if (stall_en && stall_run < 3 && $urandom_range(0, 3) == 0) begin
            hold_empty = 1'b1;
            stall_run++;
        end else begin
            hold_empty = 1'b0;
            stall_run  = 0;
        end
        present();
    end

    always @(negedge CLK) begin
        if (O_WR_PM) begin
            wr_seen++;
            checkOutput("write_expected", 64'(exp_wr.size() != 0), 64'd1);
            if (exp_wr.size() != 0) begin
                w_got = exp_wr.pop_front();
                checkOutput("write_addr", 64'(O_ADDR_PM), 64'(w_got.addr));
                checkOutput("write_data", 64'(O_DATA_PM), 64'(w_got.data));
            end
        end
        if (O_DONE || O_ERROR) begin
            evt_cyc = cyc;
            checkOutput("done_error_exclusive", 64'(O_DONE & O_ERROR), 64'd0);
            checkOutput("status_expected", 64'(exp_evt.size() != 0), 64'd1);
            if (exp_evt.size() != 0) begin
                e_got = exp_evt.pop_front();
                checkOutput("status_done", 64'(O_DONE), 64'(e_got.done));
                checkOutput("status_error", 64'(O_ERROR), 64'(!e_got.done));
                checkOutput("status_code", 64'(O_ERR_CODE), 64'(e_got.code));
            end
        end
    end

    task automatic fillWords(input int n);
        cur_words.delete();
        for (int i = 0; i < n; i++)
            cur_words.push_back($urandom);
    endtask

    // Queue a stream (header, optional body, checksum) and its expected results.
    task automatic applyStimulus(input logic [7:0] n, input logic [7:0] csum_flip,
                                 input logic exp_done, input logic [1:0] exp_code, input bit body);
        logic [7:0] x = 8'h00;
        wr_t        w;
        evt_t       e;
        push_byte(n);
        if (body) begin
            for (int i = 0; i < cur_words.size(); i++) begin
                for (int b = 3; b >= 0; b--) begin
                    push_byte(cur_words[i][8*b +: 8]);
                    x = x ^ cur_words[i][8*b +: 8];
                end
                w.addr = ADDR_W'(i);
                w.data = cur_words[i];
                exp_wr.push_back(w);
            end
            push_byte(x ^ csum_flip);
        end
        e.done = exp_done;
        e.code = exp_code;
        exp_evt.push_back(e);
    endtask

    task automatic waitDrain(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            #1;
            if (exp_evt.size() == 0 && exp_wr.size() == 0 && fifo.size() == 0 && !O_BUSY) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("drain_in_time", 64'(ok), 64'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p0;
        int w0;
        bit seen;

        vecs.push_back('{8'd1,   8'h00, 1'b0, 1'b1, 2'b00});
        vecs.push_back('{8'd3,   8'h00, 1'b1, 1'b1, 2'b00});
        vecs.push_back('{8'd2,   8'h01, 1'b0, 1'b0, 2'b11});
        vecs.push_back('{8'd0,   8'h00, 1'b0, 1'b0, 2'b01});
        vecs.push_back('{8'd33,  8'h00, 1'b0, 1'b0, 2'b01});
        vecs.push_back('{8'd200, 8'h00, 1'b0, 1'b0, 2'b01});
        vecs.push_back('{8'd32,  8'h00, 1'b1, 1'b1, 2'b00});
        vecs.push_back('{8'd5,   8'h80, 1'b1, 1'b0, 2'b11});
        vecs.push_back('{8'd16,  8'h00, 1'b0, 1'b1, 2'b00});

        // Reset state.
        I_ENABLE = 1'b1;
        repeat (2) @(negedge CLK);
        checkOutput("reset_busy",     64'(O_BUSY),     64'd0);
        checkOutput("reset_wr_pm",    64'(O_WR_PM),    64'd0);
        checkOutput("reset_status",   64'({O_DONE, O_ERROR}), 64'd0);
        checkOutput("reset_err_code", 64'(O_ERR_CODE), 64'd0);
        checkOutput("reset_loaded",   64'(O_LOADED),   64'd0);
        checkOutput("reset_n_instr",  64'(O_N_INSTR),  64'd0);
        checkOutput("reset_rd_uart",  64'(O_RD_UART),  64'd0);
        @(posedge CLK);
        #2 RESET = 1'b1;

        // Reference image: two words, checksum 0x24.
        @(posedge CLK);
        #2;
        cur_words.delete();
        cur_words.push_back(32'h20010005);
        cur_words.push_back(32'h00000000);
        p0 = pops;
        w0 = wr_seen;
        applyStimulus(8'd2, 8'h00, 1'b1, 2'b00, 1'b1);
        checkOutput("ref_csum_byte", 64'(fifo[fifo.size()-1]), 64'h24);
        waitDrain(200);
        checkOutput("ref_pops",    64'(pops - p0),    64'd10);
        checkOutput("ref_writes",  64'(wr_seen - w0), 64'd2);
        checkOutput("ref_loaded",  64'(O_LOADED),     64'd1);
        checkOutput("ref_n_instr", 64'(O_N_INSTR),    64'd2);

        // Same image with checksum 0x25.
        @(posedge CLK);
        #2;
        w0 = wr_seen;
        applyStimulus(8'd2, 8'h01, 1'b0, 2'b11, 1'b1);
        waitDrain(200);
        checkOutput("badcs_writes", 64'(wr_seen - w0), 64'd2);
        checkOutput("badcs_code",   64'(O_ERR_CODE),   64'd3);
        checkOutput("badcs_loaded", 64'(O_LOADED),     64'd0);

        // Zero count: one pop, error in the following cycle, nothing written.
        @(posedge CLK);
        #2;
        p0 = pops;
        w0 = wr_seen;
        applyStimulus(8'd0, 8'h00, 1'b0, 2'b01, 1'b0);
        waitDrain(50);
        checkOutput("zero_pops",    64'(pops - p0),            64'd1);
        checkOutput("zero_latency", 64'(evt_cyc - last_pop_cyc), 64'd0);
        checkOutput("zero_writes",  64'(wr_seen - w0),         64'd0);

        // Table-driven streams.
        foreach (vecs[k]) begin
            @(posedge CLK);
            #2;
            stall_en = vecs[k].stall;
            fillWords(int'(vecs[k].n));
            applyStimulus(vecs[k].n, vecs[k].csum_flip, vecs[k].exp_done,
                          vecs[k].exp_code, vecs[k].exp_code != 2'b01);
            waitDrain(2000);
            stall_en = 1'b0;
            checkOutput($sformatf("vec%0d_loaded", k),   64'(O_LOADED),   64'(vecs[k].exp_done));
            checkOutput($sformatf("vec%0d_err_code", k), 64'(O_ERR_CODE), 64'(vecs[k].exp_code));
            checkOutput($sformatf("vec%0d_n_instr", k),  64'(O_N_INSTR),  64'(vecs[k].n));
        end

        // Timeout: FIFO dries up after three data bytes.
        @(posedge CLK);
        #2;
        w0 = wr_seen;
        push_byte(8'd2);
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        e_got.done = 1'b0;
        e_got.code = 2'b10;
        exp_evt.push_back(e_got);
        waitDrain(200);
        checkOutput("timeout_latency", 64'(evt_cyc - last_pop_cyc), 64'(TIMEOUT_CYC));
        checkOutput("timeout_writes",  64'(wr_seen - w0),         64'd0);
        checkOutput("timeout_code",    64'(O_ERR_CODE),           64'd2);
        checkOutput("timeout_loaded",  64'(O_LOADED),             64'd0);

        // Enable low holds off popping; dropping it mid-load does not abort.
        @(posedge CLK);
        #2;
        I_ENABLE = 1'b0;
        p0 = pops;
        fillWords(1);
        applyStimulus(8'd1, 8'h00, 1'b1, 2'b00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checkOutput("disabled_rd_uart", 64'(O_RD_UART), 64'd0);
        end
        checkOutput("disabled_pops", 64'(pops - p0), 64'd0);
        @(posedge CLK);
        #2 I_ENABLE = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #2 I_ENABLE = 1'b0;
        waitDrain(200);
        checkOutput("enable_drop_loaded", 64'(O_LOADED), 64'd1);
        I_ENABLE = 1'b1;

        // Reset in the middle of a word, then a fresh stream from address 0.
        @(posedge CLK);
        #2;
        p0 = pops;
        push_byte(8'd2);
        push_byte(8'hAA);
        push_byte(8'hBB);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (pops - p0 == 3) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("midword_pops", 64'(seen), 64'd1);
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        fifo.delete();
        present();
        @(negedge CLK);
        checkOutput("midreset_busy",    64'(O_BUSY),    64'd0);
        checkOutput("midreset_n_instr", 64'(O_N_INSTR), 64'd0);
        @(posedge CLK);
        #2 RESET = 1'b1;
        @(posedge CLK);
        #2;
        fillWords(2);
        applyStimulus(8'd2, 8'h00, 1'b1, 2'b00, 1'b1);
        waitDrain(200);
        checkOutput("after_reset_loaded", 64'(O_LOADED), 64'd1);

        checkOutput("scoreboard_empty", 64'(exp_wr.size() + exp_evt.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
